// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store alignment unit.
// LSU_MISALIGN_TRAP_EN adds the ERR state; otherwise misaligned accesses are force-aligned.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
`endif

  // Shifts the addressed lane down to bit 0; upper bits are left for the caller to extend.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = word >> {off, 3'b000};
      SZ_HALF: res = word >> {off[1], 4'b0000};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] shifted;
    case (size)
      SZ_BYTE: begin
        mask    = 32'h0000_00FF << {off, 3'b000};
        shifted = {24'h0, data[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        mask    = 32'h0000_FFFF << {off[1], 4'b0000};
        shifted = {16'h0, data[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask    = 32'hFFFF_FFFF;
        shifted = data;
      end
    endcase
    return (word & ~mask) | (shifted & mask);
  endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Request/response and data-memory signals of the load/store alignment unit.
// master = datapath plus memory side, slave = lsu_align.
interface lsu_align_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load path: pick the addressed lane of the fetched word and sign/zero-extend it.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = lane_extract(word, off, size);
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit for a word-wide memory without byte enables (RMW for sub-word stores).
// LSU_MISALIGN_TRAP_EN: misaligned requests report resp_err instead of being force-aligned.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_align_if.slave  bus
);

  state_t            state, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ext_data;
  logic [1:0]        sz;
  logic [ADDR_W-1:0] addr_in;

  // Size code 11 behaves exactly like a word access.
  assign sz = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((sz == SZ_HALF) && bus.req_addr[0]) ||
                      ((sz == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign addr_in    = bus.req_addr;
`else
  always_comb begin
    addr_in = bus.req_addr;
    if (sz == SZ_HALF) addr_in[0] = 1'b0;
    else if (sz == SZ_WORD) addr_in[1:0] = 2'b00;
  end
`endif

  lsu_load_ext u_ext (
    .word        (bus.mem_rdata),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) state_d = ERR;
          else
`endif
          if (bus.req_we && (sz == SZ_WORD)) state_d = WR;
          else state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // word_q starts as the store data and is replaced by the merged word in CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            size_q  <= sz;
            uns_q   <= bus.req_unsigned;
            addr_q  <= addr_in;
            word_q  <= bus.req_wdata;
            rdata_q <= '0;
          end
        end
        CAP: begin
          if (we_q) word_q  <= lane_merge(bus.mem_rdata, word_q, addr_q[1:0], size_q);
          else      rdata_q <= ext_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_re     = (state == RD);
  assign bus.mem_we     = (state == WR);
  assign bus.mem_addr   = ((state == RD) || (state == WR)) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata  = (state == WR) ? word_q : '0;
  assign bus.resp_rdata = (state == RESP) ? rdata_q : '0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_valid = (state == RESP) || (state == ERR);
  assign bus.resp_err   = (state == ERR);
`else
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = 1'b0;
`endif

endmodule
